// File: rtl/filter_pkg.sv
// filter_pkg
// Shared definitions for the filter frame sequencer and the filter datapath.
//   seq_state_t : frame sequencer states
//   *_SLOT      : channel positions in a packed {r,g,b} pixel word; a pixel
//                 word is 3*WIDTH bits with red in the most significant slot.
package filter_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_FEED,
    S_WAIT,
    S_DRAIN,
    S_DONE
  } seq_state_t;

  localparam int CHANNELS = 3;
  localparam int R_SLOT   = 2;
  localparam int G_SLOT   = 1;
  localparam int B_SLOT   = 0;

  // Width of a packed {r,g,b} pixel for a given channel width.
  function automatic int pix_w(input int width);
    return CHANNELS * width;
  endfunction

endpackage

// File: rtl/filter_frame_sequencer_if.sv
// filter_frame_sequencer_if
// Bundles every signal of the frame sequencer except clk/reset.
//   host   : start, abort -> ; busy, frame_done, err_timeout <-
//   source : src_rd_en, src_rd_addr -> ; src_rd_data <- (1-cycle latency)
//   filter : r/g/b_data_in, data_in_done -> ; r/g/b_data_out, data_out_done <-
//   dest   : dst_wr_en, dst_wr_addr, dst_wr_data ->
// master = sequencer side, slave = host / memories / filter side.
interface filter_frame_sequencer_if #(
  parameter int WIDTH     = 8,
  parameter int ADDR_BITS = 10
);
  localparam int PIX_W = 3 * WIDTH;

  logic                 start;
  logic                 abort;
  logic                 busy;
  logic                 frame_done;
  logic                 err_timeout;

  logic                 src_rd_en;
  logic [ADDR_BITS-1:0] src_rd_addr;
  logic [PIX_W-1:0]     src_rd_data;

  logic [WIDTH-1:0]     r_data_in;
  logic [WIDTH-1:0]     g_data_in;
  logic [WIDTH-1:0]     b_data_in;
  logic                 data_in_done;

  logic [WIDTH-1:0]     r_data_out;
  logic [WIDTH-1:0]     g_data_out;
  logic [WIDTH-1:0]     b_data_out;
  logic                 data_out_done;

  logic                 dst_wr_en;
  logic [ADDR_BITS-1:0] dst_wr_addr;
  logic [PIX_W-1:0]     dst_wr_data;

  modport master (
    input  start, abort, src_rd_data,
           r_data_out, g_data_out, b_data_out, data_out_done,
    output busy, frame_done, err_timeout, src_rd_en, src_rd_addr,
           r_data_in, g_data_in, b_data_in, data_in_done,
           dst_wr_en, dst_wr_addr, dst_wr_data
  );

  modport slave (
    output start, abort, src_rd_data,
           r_data_out, g_data_out, b_data_out, data_out_done,
    input  busy, frame_done, err_timeout, src_rd_en, src_rd_addr,
           r_data_in, g_data_in, b_data_in, data_in_done,
           dst_wr_en, dst_wr_addr, dst_wr_data
  );

endinterface

// File: rtl/filter_frame_sequencer_pixel_counter.sv
// pixel_counter
// Unsigned up-counter with synchronous clear, enable and terminal-count flag.
//   clk, reset : clock, synchronous active-low reset
//   i_clr      : clear to zero (priority over i_en)
//   i_en       : increment by one
//   o_cnt      : current count
//   o_tc       : high while o_cnt == TERM
module pixel_counter #(
  parameter int CNT_W = 11,
  parameter int TERM  = 30
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_clr,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_tc
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_cnt <= '0;
    end else if (i_clr) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == CNT_W'(TERM));

endmodule

// File: rtl/filter_frame_sequencer.sv
// filter_frame_sequencer
// Streams one ROWS x COLS RGB frame from a source memory through the filter
// and writes the filtered pixels to a destination memory.
//   clk, reset : clock, synchronous active-low reset
//   bus        : filter_frame_sequencer_if master (host control/status,
//                source read port, filter in/out streams, destination write)
module filter_frame_sequencer #(
  parameter int WIDTH         = 8,
  parameter int ROWS          = 5,
  parameter int COLS          = 6,
  parameter int ADDR_BITS     = 10,
  parameter int DRAIN_TIMEOUT = 64
) (
  input  logic                      clk,
  input  logic                      reset,
  filter_frame_sequencer_if.master  bus
);
  import filter_pkg::*;

  localparam int NPIX  = ROWS * COLS;
  localparam int CW    = ADDR_BITS + 1;
  localparam int PIX_W = pix_w(WIDTH);

  seq_state_t       r_state;
  seq_state_t       w_state_next;
  logic             r_busy;
  logic             r_err;
  logic             r_rd_pend;
  logic             r_in_done;
  logic [PIX_W-1:0] r_pix;
  logic [CW-1:0]    r_timer;

  logic             w_start_acc;
  logic             w_set_err;
  logic             w_kill;
  logic             w_rd_en;
  logic             w_capture;
  logic             w_wr_en;
  logic             w_timeout;
  logic             w_out_last;
  logic [CW-1:0]    w_rd_cnt;
  logic [CW-1:0]    w_in_cnt;
  logic [CW-1:0]    w_out_cnt;
  logic             w_rd_last;
  logic             w_in_tc;
  logic             w_out_tc;
  logic             w_unused;

  assign w_kill    = bus.abort && (r_state != S_IDLE);
  assign w_rd_en   = (r_state == S_FEED);
  assign w_capture = (r_state == S_FEED) || (r_state == S_WAIT) || (r_state == S_DRAIN);
  assign w_wr_en   = bus.data_out_done && w_capture && !w_out_tc;

  // Look ahead on the write that brings out_cnt to NPIX so frame_done
  // follows the final write by exactly one cycle.
  assign w_out_last = w_out_tc || (w_wr_en && (w_out_cnt == CW'(NPIX - 1)));

  // The timer ticks once per DRAIN cycle; this is the cycle whose tick
  // brings it to DRAIN_TIMEOUT.
  assign w_timeout = (r_timer == CW'(DRAIN_TIMEOUT - 1));

  pixel_counter #(.CNT_W(CW), .TERM(NPIX - 1)) u_rd_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_start_acc),
    .i_en  (w_rd_en),
    .o_cnt (w_rd_cnt),
    .o_tc  (w_rd_last)
  );

  pixel_counter #(.CNT_W(CW), .TERM(NPIX)) u_in_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_start_acc),
    .i_en  (r_in_done),
    .o_cnt (w_in_cnt),
    .o_tc  (w_in_tc)
  );

  pixel_counter #(.CNT_W(CW), .TERM(NPIX)) u_out_cnt (
    .clk   (clk),
    .reset (reset),
    .i_clr (w_start_acc),
    .i_en  (w_wr_en),
    .o_cnt (w_out_cnt),
    .o_tc  (w_out_tc)
  );

  always_comb begin
    w_state_next = r_state;
    w_start_acc  = 1'b0;
    w_set_err    = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (bus.start) begin
          w_state_next = S_FEED;
          w_start_acc  = 1'b1;
        end
      end
      S_FEED:  if (w_rd_last) w_state_next = S_WAIT;
      S_WAIT:  if (w_in_tc)   w_state_next = S_DRAIN;
      S_DRAIN: begin
        if (w_out_last) begin
          w_state_next = S_DONE;
        end else if (w_timeout) begin
          w_state_next = S_DONE;
          w_set_err    = 1'b1;
        end
      end
      S_DONE:  w_state_next = S_IDLE;
      default: w_state_next = S_IDLE;
    endcase
    // Abort overrides everything and leaves err_timeout untouched.
    if (w_kill) begin
      w_state_next = S_IDLE;
      w_set_err    = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_busy    <= 1'b0;
      r_err     <= 1'b0;
      r_rd_pend <= 1'b0;
      r_in_done <= 1'b0;
      r_pix     <= '0;
      r_timer   <= '0;
    end else begin
      r_busy <= (w_state_next == S_FEED) || (w_state_next == S_WAIT) ||
                (w_state_next == S_DRAIN);
      if (w_start_acc) begin
        r_err <= 1'b0;
      end else if (w_set_err) begin
        r_err <= 1'b1;
      end
      // Reads still in flight when the frame is aborted never reach the filter.
      r_rd_pend <= w_rd_en && !w_kill;
      r_in_done <= r_rd_pend && !w_kill;
      if (r_rd_pend) begin
        r_pix <= bus.src_rd_data;
      end
      if (w_start_acc) begin
        r_timer <= '0;
      end else if (r_state == S_DRAIN) begin
        r_timer <= r_timer + 1'b1;
      end
    end
  end

  assign bus.busy         = r_busy;
  assign bus.frame_done   = (r_state == S_DONE) && !bus.abort;
  assign bus.err_timeout  = r_err;
  assign bus.src_rd_en    = w_rd_en;
  assign bus.src_rd_addr  = w_rd_cnt[ADDR_BITS-1:0];
  assign bus.r_data_in    = r_pix[R_SLOT*WIDTH +: WIDTH];
  assign bus.g_data_in    = r_pix[G_SLOT*WIDTH +: WIDTH];
  assign bus.b_data_in    = r_pix[B_SLOT*WIDTH +: WIDTH];
  assign bus.data_in_done = r_in_done;
  assign bus.dst_wr_en    = w_wr_en;
  assign bus.dst_wr_addr  = w_out_cnt[ADDR_BITS-1:0];
  assign bus.dst_wr_data  = w_wr_en ? {bus.r_data_out, bus.g_data_out, bus.b_data_out} : '0;

  // Counter MSBs exist only so a frame never wraps; in_cnt is used via its flag.
  assign w_unused = ^{w_rd_cnt[CW-1], w_out_cnt[CW-1], w_in_cnt};

endmodule

// File: tb/tb_filter_frame_sequencer.sv
`timescale 1ns/1ps
module tb_filter_frame_sequencer;
  localparam int WIDTH = 8, ROWS = 5, COLS = 6, ADDR_BITS = 10, DRAIN_TIMEOUT = 64;
  localparam int N = ROWS * COLS;
  localparam int LAT = 9;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  filter_frame_sequencer_if #(.WIDTH(WIDTH), .ADDR_BITS(ADDR_BITS)) bus();

  filter_frame_sequencer #(
    .WIDTH(WIDTH), .ROWS(ROWS), .COLS(COLS),
    .ADDR_BITS(ADDR_BITS), .DRAIN_TIMEOUT(DRAIN_TIMEOUT)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct {
    logic [23:0] pix;
    int          due;
  } fout_t;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  logic [23:0] src_mem [N];
  fout_t       fq [$];
  int          f_withhold = 0;
  bit          f_extra = 0;
  int          f_emitted = 0;
  bit          mem_pend = 0;
  int          mem_addr = 0;
  bit          mdl_capture = 0;
  int          rd_n, in_n, wr_n, done_n, s_cyc, done_cyc, last_wr_addr;
  logic        done_err;
  int          rd_cyc [N];
  int          in_cyc [N];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Model observation, once per cycle at the falling edge.
  task automatic compare_cycle();
    logic exp_wr;
    if (bus.frame_done) begin
      done_n++;
      done_cyc = cyc;
      done_err = bus.err_timeout;
      mdl_capture = 0;
      $display("DONE cycle=%0d rel=%0d err_timeout=%0b writes=%0d", cyc, cyc - s_cyc, bus.err_timeout, wr_n);
    end
    if (bus.src_rd_en) begin
      chk("rd_addr", 64'(bus.src_rd_addr), 64'(rd_n));
      chk("rd_in_range", 64'(rd_n < N), 64'd1);
      if (rd_n < N) rd_cyc[rd_n] = cyc;
      rd_n++;
      mem_pend = 1;
      mem_addr = int'(bus.src_rd_addr);
    end else begin
      mem_pend = 0;
    end
    if (bus.data_in_done) begin
      chk("in_in_range", 64'(in_n < N), 64'd1);
      if (in_n < N) begin
        chk("in_pix", 64'({bus.r_data_in, bus.g_data_in, bus.b_data_in}), 64'(src_mem[in_n]));
        chk("in_latency", 64'(cyc - rd_cyc[in_n]), 64'd2);
        in_cyc[in_n] = cyc;
        if (in_n < N - f_withhold)
          fq.push_back('{pix: {bus.r_data_in, bus.g_data_in, bus.b_data_in}, due: cyc + LAT});
        if (f_extra && in_n == N - 1)
          fq.push_back('{pix: {bus.r_data_in, bus.g_data_in, bus.b_data_in}, due: cyc + LAT + 1});
      end
      in_n++;
    end
    exp_wr = bus.data_out_done && mdl_capture && (wr_n < N);
    if (bus.data_out_done || bus.dst_wr_en)
      chk("wr_en", 64'(bus.dst_wr_en), 64'(exp_wr));
    if (bus.dst_wr_en) begin
      $display("WR addr=%0d data=%06h cycle=%0d", bus.dst_wr_addr, bus.dst_wr_data, cyc);
      chk("wr_addr", 64'(bus.dst_wr_addr), 64'(wr_n));
      if (wr_n < N) chk("wr_data", 64'(bus.dst_wr_data), 64'(src_mem[wr_n]));
      last_wr_addr = int'(bus.dst_wr_addr);
      wr_n++;
    end
  endtask

  // Source memory (1-cycle read) and identity filter with fixed latency.
  task automatic drive_models();
    fout_t f;
    bus.src_rd_data = (mem_pend && mem_addr < N) ? src_mem[mem_addr] : 24'h0;
    if (fq.size() > 0 && fq[0].due <= cyc) begin
      f = fq.pop_front();
      bus.data_out_done = 1'b1;
      {bus.r_data_out, bus.g_data_out, bus.b_data_out} = f.pix;
      f_emitted++;
    end else begin
      bus.data_out_done = 1'b0;
    end
  endtask

  task automatic tick();
    @(negedge clk);
    compare_cycle();
    @(posedge clk);
    cyc++;
    #1;
    drive_models();
  endtask

  task automatic launch();
    rd_n = 0; in_n = 0; wr_n = 0; done_n = 0; done_cyc = -1; done_err = 1'bx;
    last_wr_addr = -1; f_emitted = 0;
    fq.delete();
    bus.start = 1'b1;
    s_cyc = cyc;
    tick();
    bus.start = 1'b0;
    mdl_capture = 1;
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (done_n == 0 && k < budget) begin
      tick();
      k++;
    end
    chk({name, "_done_within_budget"}, 64'(done_n > 0), 64'd1);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_busy"}, 64'(bus.busy), 64'd0);
    chk({tag, "_frame_done"}, 64'(bus.frame_done), 64'd0);
    chk({tag, "_err"}, 64'(bus.err_timeout), 64'd0);
    chk({tag, "_rd_en"}, 64'(bus.src_rd_en), 64'd0);
    chk({tag, "_in_done"}, 64'(bus.data_in_done), 64'd0);
    chk({tag, "_wr_en"}, 64'(bus.dst_wr_en), 64'd0);
    chk({tag, "_rd_addr"}, 64'(bus.src_rd_addr), 64'd0);
    chk({tag, "_wr_addr"}, 64'(bus.dst_wr_addr), 64'd0);
    chk({tag, "_wr_data"}, 64'(bus.dst_wr_data), 64'd0);
    chk({tag, "_data_in"}, 64'({bus.r_data_in, bus.g_data_in, bus.b_data_in}), 64'd0);
  endtask

  initial begin
    for (int i = 0; i < N; i++) src_mem[i] = {8'(i), 8'(i + 1), 8'(i + 2)};
    bus.start = 1'b0; bus.abort = 1'b0; bus.src_rd_data = '0;
    bus.r_data_out = '0; bus.g_data_out = '0; bus.b_data_out = '0; bus.data_out_done = 1'b0;

    // Reset state
    idle(3);
    check_zero("reset");
    reset = 1'b1;
    idle(2);

    // Nominal frame
    launch();
    chk("nom_busy_after_start", 64'(bus.busy), 64'd1);
    wait_done("nom", 150);
    idle(5);
    chk("nom_reads", 64'(rd_n), 64'd30);
    chk("nom_inputs", 64'(in_n), 64'd30);
    chk("nom_writes", 64'(wr_n), 64'd30);
    chk("nom_done_pulses", 64'(done_n), 64'd1);
    chk("nom_done_err", 64'(done_err), 64'd0);
    chk("nom_first_rd_rel", 64'(rd_cyc[0] - s_cyc), 64'd1);
    chk("nom_last_rd_rel", 64'(rd_cyc[N-1] - s_cyc), 64'd30);
    chk("nom_first_in_rel", 64'(in_cyc[0] - s_cyc), 64'd3);
    chk("nom_last_in_rel", 64'(in_cyc[N-1] - s_cyc), 64'd32);
    chk("nom_done_rel", 64'(done_cyc - s_cyc), 64'd42);
    chk("nom_last_wr_addr", 64'(last_wr_addr), 64'd29);
    chk("nom_busy_idle", 64'(bus.busy), 64'd0);

    // Timeout: last two outputs withheld
    f_withhold = 2;
    launch();
    wait_done("tmo", 200);
    idle(5);
    chk("tmo_writes", 64'(wr_n), 64'd28);
    chk("tmo_done_err", 64'(done_err), 64'd1);
    chk("tmo_done_rel", 64'(done_cyc - s_cyc), 64'd98);
    chk("tmo_done_pulses", 64'(done_n), 64'd1);
    chk("tmo_err_sticky", 64'(bus.err_timeout), 64'd1);
    chk("tmo_busy_idle", 64'(bus.busy), 64'd0);

    // Restart after error
    f_withhold = 0;
    launch();
    chk("rst_err_cleared", 64'(bus.err_timeout), 64'd0);
    wait_done("restart", 150);
    idle(5);
    chk("restart_writes", 64'(wr_n), 64'd30);
    chk("restart_done_err", 64'(done_err), 64'd0);
    chk("restart_done_pulses", 64'(done_n), 64'd1);

    // Abort in FEED cycle 10
    launch();
    idle(9);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    mdl_capture = 0;
    chk("abort_busy", 64'(bus.busy), 64'd0);
    idle(30);
    chk("abort_reads", 64'(rd_n), 64'd10);
    chk("abort_writes", 64'(wr_n), 64'd0);
    chk("abort_done_pulses", 64'(done_n), 64'd0);
    chk("abort_busy_end", 64'(bus.busy), 64'd0);
    chk("abort_err_unchanged", 64'(bus.err_timeout), 64'd0);

    // Excess filter strobe and ignored mid-FEED start
    f_extra = 1;
    launch();
    idle(4);
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
    wait_done("excess", 150);
    idle(5);
    chk("excess_strobes", 64'(f_emitted), 64'd31);
    chk("excess_writes", 64'(wr_n), 64'd30);
    chk("excess_last_wr_addr", 64'(last_wr_addr), 64'd29);
    chk("excess_reads", 64'(rd_n), 64'd30);
    chk("excess_last_rd_rel", 64'(rd_cyc[N-1] - s_cyc), 64'd30);
    chk("excess_done_pulses", 64'(done_n), 64'd1);
    f_extra = 0;

    // Reset during DRAIN, then a full frame
    launch();
    idle(35);
    chk("rstmid_busy_drain", 64'(bus.busy), 64'd1);
    reset = 1'b0;
    tick();
    reset = 1'b1;
    mdl_capture = 0;
    check_zero("rstmid");
    idle(15);
    launch();
    wait_done("post_rst", 150);
    idle(5);
    chk("post_rst_reads", 64'(rd_n), 64'd30);
    chk("post_rst_writes", 64'(wr_n), 64'd30);
    chk("post_rst_done_pulses", 64'(done_n), 64'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
